// File: rtl/temp_mon_pkg.sv
// Shared types and default thresholds for the body-temperature monitor.
package temp_mon_pkg;

   typedef enum logic [1:0] {
      T_NORMAL = 2'd0,
      T_LOW    = 2'd1,
      T_HIGH   = 2'd2
   } temp_state_e;

   localparam int unsigned TEMP_W      = 8;
   localparam int unsigned CNT_W       = 4;
   localparam int unsigned LOW_TH_DEF  = 95;
   localparam int unsigned HIGH_TH_DEF = 100;
   localparam int unsigned HYST_DEF    = 1;

endpackage

// File: rtl/temp_mon_persist_filter.sv
// Persistence filter: a raw class must repeat PERSIST valid samples before it
// is confirmed; produces the next confirmed state combinationally.
module temp_persist_filter
   import temp_mon_pkg::*;
#(
   parameter int unsigned PERSIST = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid,
   input  temp_state_e raw,
   input  temp_state_e state,
   output temp_state_e state_next_c
);

   temp_state_e      cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;

   // Candidate/counter update; invalid cycles leave everything untouched.
   always_comb begin
      cand_d       = cand_q;
      cnt_d        = cnt_q;
      cnt_inc      = cnt_q;
      state_next_c = state;
      if (valid) begin
         if (raw == state) begin
            cnt_d = '0;
         end else begin
            if (raw == cand_q) begin
               cnt_inc = (cnt_q >= CNT_W'(PERSIST)) ? CNT_W'(PERSIST)
                                                     : cnt_q + CNT_W'(1);
            end else begin
               cand_d  = raw;
               cnt_inc = CNT_W'(1);
            end
            if (cnt_inc == CNT_W'(PERSIST)) begin
               state_next_c = raw;
               cnt_d        = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cand_q <= T_NORMAL;
         cnt_q  <= '0;
      end else begin
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/temperature_monitor.sv
// Body-temperature classifier: threshold/hysteresis classification feeding a
// persistence filter, with registered HIGH/LOW/abnormal flags.
module temperature_monitor
   import temp_mon_pkg::*;
#(
   parameter int unsigned LOW_TH  = LOW_TH_DEF,
   parameter int unsigned HIGH_TH = HIGH_TH_DEF,
   parameter int unsigned HYST    = HYST_DEF,
   parameter int unsigned PERSIST = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [TEMP_W-1:0] temperature,
   input  logic              temp_valid,
   output logic              temp_high,
   output logic              temp_low,
   output logic              temp_state
);

   localparam int unsigned HIGH_HOLD = HIGH_TH - HYST;
   localparam int unsigned LOW_HOLD  = LOW_TH + HYST;

   temp_state_e state_q;
   temp_state_e state_d;
   temp_state_e raw_c;
   logic        high_d;
   logic        low_d;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= T_NORMAL;
      else     state_q <= state_d;
   end

   // Raw class; the exit threshold of an alarm state is widened by HYST.
   always_comb begin
      raw_c = T_NORMAL;
      unique case (state_q)
         T_HIGH: begin
            if (temperature >= TEMP_W'(HIGH_HOLD))   raw_c = T_HIGH;
            else if (temperature <= TEMP_W'(LOW_TH)) raw_c = T_LOW;
         end
         T_LOW: begin
            if (temperature <= TEMP_W'(LOW_HOLD))     raw_c = T_LOW;
            else if (temperature >= TEMP_W'(HIGH_TH)) raw_c = T_HIGH;
         end
         default: begin
            if (temperature >= TEMP_W'(HIGH_TH))     raw_c = T_HIGH;
            else if (temperature <= TEMP_W'(LOW_TH)) raw_c = T_LOW;
         end
      endcase
   end

   temp_persist_filter #(
      .PERSIST (PERSIST)
   ) u_filter (
      .clk          (clk),
      .rst          (rst),
      .valid        (temp_valid),
      .raw          (raw_c),
      .state        (state_q),
      .state_next_c (state_d)
   );

   // Output decode from the next state so the flags track the state register.
   always_comb begin
      high_d = 1'b0;
      low_d  = 1'b0;
      if (state_d == T_HIGH) high_d = 1'b1;
      if (state_d == T_LOW)  low_d  = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         temp_high  <= 1'b0;
         temp_low   <= 1'b0;
         temp_state <= 1'b0;
      end else begin
         temp_high  <= high_d;
         temp_low   <= low_d;
         temp_state <= high_d | low_d;
      end
   end

endmodule

// File: tb/tb_temperature_monitor.sv
// Scoreboard bench: two monitors (PERSIST=1 and PERSIST=2) driven with
// directed vectors; expected flags are queued per cycle and checked by a monitor.
module tb_temperature_monitor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] t1 = 8'd0, t2 = 8'd0;
   logic       v1 = 1'b0, v2 = 1'b0;
   logic       h1, l1, s1, h2, l2, s2;

   int tests = 0;
   int fails = 0;

   typedef struct {
      bit    c1;
      bit    eh1;
      bit    el1;
      bit    c2;
      bit    eh2;
      bit    el2;
      string name;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;

   always #5 clk = ~clk;

   temperature_monitor #(.PERSIST(1)) dut1 (
      .clk         (clk),
      .rst         (rst),
      .temperature (t1),
      .temp_valid  (v1),
      .temp_high   (h1),
      .temp_low    (l1),
      .temp_state  (s1)
   );

   temperature_monitor #(.PERSIST(2)) dut2 (
      .clk         (clk),
      .rst         (rst),
      .temperature (t2),
      .temp_valid  (v2),
      .temp_high   (h2),
      .temp_low    (l2),
      .temp_state  (s2)
   );

   task automatic check(input string n, input logic act, input logic req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%b required=%b", n, act, req);
      end
   endtask

   // Monitor: pops one expectation per clock, after the edge has settled.
   always @(posedge clk) begin
      #2;
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         check({cur.name, "/p1_state_eq_or"}, s1, h1 | l1);
         check({cur.name, "/p1_exclusive"}, h1 & l1, 1'b0);
         check({cur.name, "/p2_state_eq_or"}, s2, h2 | l2);
         check({cur.name, "/p2_exclusive"}, h2 & l2, 1'b0);
         if (cur.c1) begin
            check({cur.name, "/p1_high"}, h1, cur.eh1);
            check({cur.name, "/p1_low"}, l1, cur.el1);
            check({cur.name, "/p1_state"}, s1, cur.eh1 | cur.el1);
         end
         if (cur.c2) begin
            check({cur.name, "/p2_high"}, h2, cur.eh2);
            check({cur.name, "/p2_low"}, l2, cur.el2);
            check({cur.name, "/p2_state"}, s2, cur.eh2 | cur.el2);
         end
      end
   end

   task automatic cyc(input bit r, input logic [7:0] a, input bit va,
                      input logic [7:0] b, input bit vb, input exp_t e);
      @(negedge clk);
      rst = r;
      t1  = a;
      v1  = va;
      t2  = b;
      v2  = vb;
      exp_q.push_back(e);
   endtask

   // Drive only the PERSIST=2 instance.
   task automatic d2(input logic [7:0] tv, input bit vv, input bit eh, input bit el,
                     input string n);
      exp_t e;
      e = '{c1: 1'b0, eh1: 1'b0, el1: 1'b0, c2: 1'b1, eh2: eh, el2: el, name: n};
      cyc(1'b0, 8'd0, 1'b0, tv, vv, e);
   endtask

   // Drive only the PERSIST=1 instance.
   task automatic d1(input logic [7:0] tv, input bit eh, input bit el, input string n);
      exp_t e;
      e = '{c1: 1'b1, eh1: eh, el1: el, c2: 1'b0, eh2: 1'b0, el2: 1'b0, name: n};
      cyc(1'b0, tv, 1'b1, 8'd0, 1'b0, e);
   endtask

   initial begin
      exp_t e;
      logic [7:0] r;

      // Reset with a hot sample on both instances
      e = '{c1: 1'b1, eh1: 1'b0, el1: 1'b0, c2: 1'b1, eh2: 1'b0, el2: 1'b0, name: "reset"};
      cyc(1'b1, 8'd105, 1'b1, 8'd105, 1'b1, e);
      cyc(1'b1, 8'd105, 1'b1, 8'd105, 1'b1, e);

      // PERSIST=2: rise after two valid samples, fall after two normal ones
      d2(8'd105, 1'b1, 1'b0, 1'b0, "rst_rel_1");
      d2(8'd105, 1'b1, 1'b1, 1'b0, "rst_rel_2");
      d2(8'd97,  1'b1, 1'b1, 1'b0, "fall_1");
      d2(8'd97,  1'b1, 1'b0, 1'b0, "fall_2");

      // Interrupted streak
      d2(8'd98,  1'b1, 1'b0, 1'b0, "pers_98a");
      d2(8'd102, 1'b1, 1'b0, 1'b0, "pers_102a");
      d2(8'd98,  1'b1, 1'b0, 1'b0, "pers_98b");
      d2(8'd102, 1'b1, 1'b0, 1'b0, "pers_102b");
      d2(8'd102, 1'b1, 1'b1, 1'b0, "pers_102c");
      d2(8'd97,  1'b1, 1'b1, 1'b0, "pers_fall_1");
      d2(8'd97,  1'b1, 1'b0, 1'b0, "pers_fall_2");

      // Valid gating: invalid 90s are ignored between two valid 102s
      d2(8'd102, 1'b1, 1'b0, 1'b0, "gate_102a");
      d2(8'd90,  1'b0, 1'b0, 1'b0, "gate_inv1");
      d2(8'd90,  1'b0, 1'b0, 1'b0, "gate_inv2");
      d2(8'd90,  1'b0, 1'b0, 1'b0, "gate_inv3");
      d2(8'd102, 1'b1, 1'b1, 1'b0, "gate_102b");

      // Direct HIGH -> LOW swing
      d2(8'd88,  1'b1, 1'b1, 1'b0, "swing_1");
      d2(8'd88,  1'b1, 1'b0, 1'b1, "swing_2");

      // Reset mid-streak discards the partial candidate
      d2(8'd102, 1'b1, 1'b0, 1'b1, "mid_partial");
      e = '{c1: 1'b1, eh1: 1'b0, el1: 1'b0, c2: 1'b1, eh2: 1'b0, el2: 1'b0, name: "mid_rst"};
      cyc(1'b1, 8'd0, 1'b0, 8'd102, 1'b1, e);
      d2(8'd102, 1'b1, 1'b0, 1'b0, "mid_after_1");
      d2(8'd102, 1'b1, 1'b1, 1'b0, "mid_after_2");

      // PERSIST=1 thresholds
      d1(8'd95,  1'b0, 1'b1, "th_95");
      d1(8'd97,  1'b0, 1'b0, "th_97");
      d1(8'd96,  1'b0, 1'b0, "th_96");
      d1(8'd99,  1'b0, 1'b0, "th_99");
      d1(8'd100, 1'b1, 1'b0, "th_100");
      d1(8'd97,  1'b0, 1'b0, "th_97b");

      // PERSIST=1 hysteresis
      d1(8'd100, 1'b1, 1'b0, "hy_100");
      d1(8'd99,  1'b1, 1'b0, "hy_99");
      d1(8'd98,  1'b0, 1'b0, "hy_98");
      d1(8'd95,  1'b0, 1'b1, "hy_95");
      d1(8'd96,  1'b0, 1'b1, "hy_96");
      d1(8'd97,  1'b0, 1'b0, "hy_97");

      // Extreme codes classify normally
      d1(8'd0,   1'b0, 1'b1, "ext_0");
      d1(8'd255, 1'b1, 1'b0, "ext_255");
      d1(8'd98,  1'b0, 1'b0, "ext_98");

      // Random valid samples: invariants only
      for (int i = 0; i < 40; i++) begin
         r = 8'($urandom_range(110, 85));
         e = '{c1: 1'b0, eh1: 1'b0, el1: 1'b0, c2: 1'b0, eh2: 1'b0, el2: 1'b0, name: "rand"};
         cyc(1'b0, r, 1'b1, r, 1'b1, e);
      end

      @(negedge clk);
      v1 = 1'b0;
      v2 = 1'b0;
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #5;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain actual=%0d required=0 pending", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
